silife_population_counter: RTL

SILIFE_POPULATION_COUNTER -- requirements
Module: silife_population_counter

---
 rtl/silife_population_counter_if.sv | 30 +++
 rtl/silife_population_counter.sv | 109 ++++++++++
 2 files changed

// File: rtl/silife_population_counter_if.sv
// Bus between the population counter and the grid/host side.
// The grid returns the cells of row o_row_select on i_cells in the same cycle.
interface silife_population_counter_if #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32
);
   localparam int ROW_BITS = $clog2(HEIGHT);
   localparam int POP_BITS = $clog2(WIDTH*HEIGHT+1);

   logic                i_start;
   logic                i_clear_stats;
   logic [ROW_BITS-1:0] o_row_select;
   logic [WIDTH-1:0]    i_cells;
   logic                o_busy;
   logic                o_done;
   logic [POP_BITS-1:0] o_population;
   logic [POP_BITS-1:0] o_peak;
   logic [15:0]         o_generation;
   logic                o_extinct;

   modport master (
      output i_start, i_clear_stats, i_cells,
      input  o_row_select, o_busy, o_done, o_population, o_peak, o_generation, o_extinct
   );

   modport slave (
      input  i_start, i_clear_stats, i_cells,
      output o_row_select, o_busy, o_done, o_population, o_peak, o_generation, o_extinct
   );
endinterface

// File: rtl/silife_population_counter.sv
// Scans a Game-of-Life grid one row per clock and publishes the live-cell count
// together with peak and generation statistics.
//
// state  | meaning
// IDLE   | waiting for i_start, row address parked at 0
// SCAN   | adding popcount of one row per cycle
// FINISH | publishing the accumulated count, pulsing o_done
module silife_population_counter #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   silife_population_counter_if.slave  bus
);
   localparam int ROW_BITS = $clog2(HEIGHT);
   localparam int POP_BITS = $clog2(WIDTH*HEIGHT+1);
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(HEIGHT-1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t              state_q;
   logic [ROW_BITS-1:0] row_q;
   logic [POP_BITS-1:0] acc_q;
   logic [POP_BITS-1:0] pop_q;
   logic [POP_BITS-1:0] peak_q;
   logic [15:0]         gen_q;
   logic                busy_q;
   logic                done_q;
   logic                extinct_q;
   logic [POP_BITS-1:0] row_count_d;

   always_comb begin
      row_count_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         row_count_d = row_count_d + POP_BITS'(bus.i_cells[i]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         acc_q     <= '0;
         pop_q     <= '0;
         peak_q    <= '0;
         gen_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         extinct_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.i_clear_stats) begin
            peak_q <= '0;
            gen_q  <= '0;
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.i_start) begin
                  state_q <= ST_SCAN;
                  row_q   <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_SCAN: begin
               acc_q <= acc_q + row_count_d;
               if (row_q == LAST_ROW) begin
                  row_q   <= '0;
                  state_q <= ST_FINISH;
               end else begin
                  row_q <= row_q + ROW_BITS'(1);
               end
            end
            ST_FINISH: begin
               pop_q     <= acc_q;
               done_q    <= 1'b1;
               extinct_q <= (acc_q == '0);
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
               // A simultaneous clear wins over the statistics update.
               if (!bus.i_clear_stats) begin
                  gen_q <= gen_q + 16'd1;
                  if (acc_q > peak_q) begin
                     peak_q <= acc_q;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               row_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_row_select = row_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_done       = done_q;
   assign bus.o_population = pop_q;
   assign bus.o_peak       = peak_q;
   assign bus.o_generation = gen_q;
   assign bus.o_extinct    = extinct_q;
endmodule
